mp_control_fsm: RTL and testbench
=================================

Name: mp_control_fsm

Overview:
- Multicycle control unit for the Microprocesador datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath enable and select from the instruction-register opcode and the Zero flag.
- Waits on a memory ready handshake, with a timeout.
- Halts on HLT, an illegal opcode or a bus timeout. Only Reset leaves the halted state.

Parameters:
- OPW, 4, opcode width.
- TMO, 15, maximum wait cycles for Mem_Ready before a bus error (1..255).
- CNTW, 16, width of the retired-instruction counter.

Ports:
- Clk  in  1  system clock; everything updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Opcode  in  OPW  IR[15:12] as currently held in the IR.
- Zero  in  1  ALU zero flag, combinational from the datapath.
- Mem_Ready  in  1  memory completes the current access this cycle.
- PC_En  out  1  load the PC.
- PC_Src  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump target.
- IR_En  out  1  load the IR from memory data.
- Mem_Rd  out  1  memory read request.
- Mem_Wr  out  1  memory write request.
- Addr_Src  out  1  address source: 0 = PC, 1 = ALU result register.
- ALU_Op  out  2  ALU function: 0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
- ALU_SrcB  out  1  ALU B operand: 0 = register, 1 = immediate.
- Reg_Wr  out  1  register file write enable.
- Wb_Src  out  1  writeback source: 0 = ALU, 1 = memory data.
- Halted  out  1  core is stopped.
- Err  out  2  error code: 0 = none, 1 = illegal opcode, 2 = bus timeout. Sticky until Reset.
- Instr_Count  out  CNTW  number of retired instructions.

Behaviour:
- Reset, on the Clk edge while Reset = 1:
  - state goes to FETCH;
  - wait counter, Err, Instr_Count and Halted go to 0;
  - all registered outputs go to 0.
  - Reset has priority over every other event, including mid-wait and HALT.
- Outputs are a Moore decode of the state plus the Opcode, except IR_En and PC_En in FETCH, which are gated by Mem_Ready.
- Any output not listed for a state is 0.
- Opcodes:
  - 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LD, 7 ST, 8 BEQ, 9 JMP, F HLT.
  - A..E are illegal.
- FETCH:
  - Mem_Rd = 1, Addr_Src = 0.
  - On the cycle Mem_Ready = 1: IR_En = 1, PC_En = 1, PC_Src = 0, then go to DECODE.
  - While Mem_Ready = 0: stay in FETCH and increment the wait counter.
- DECODE:
  - NOP: Instr_Count += 1, go to FETCH.
  - HLT: go to HALT.
  - Illegal: Err = 1, go to HALT.
  - Any other opcode: go to EXEC.
- EXEC:
  - ALU_Op: ADD/ADDI/LD/ST use 0, SUB/BEQ use 1, AND uses 2, OR uses 3.
  - ALU_SrcB = 1 for ADDI, LD and ST.
  - BEQ: PC_En = Zero, PC_Src = 1, Instr_Count += 1, go to FETCH.
  - JMP: PC_En = 1, PC_Src = 2, Instr_Count += 1, go to FETCH.
  - LD and ST: go to MEM.
  - Otherwise: go to WB.
- MEM:
  - Addr_Src = 1; Mem_Rd = 1 for LD, Mem_Wr = 1 for ST.
  - Hold until Mem_Ready = 1.
  - Then ST goes to FETCH with Instr_Count += 1; LD goes to WB.
- WB:
  - Reg_Wr = 1; Wb_Src = 1 for LD, 0 otherwise.
  - Instr_Count += 1, go to FETCH.
- HALT: Halted = 1; all enables and requests are 0; the state is absorbing.
- Wait counter:
  - Cleared on entry to FETCH or MEM and when Mem_Ready = 1.
  - If it reaches TMO while still waiting: Err = 2 and go to HALT on the next edge, with no IR, PC or register write.
  - Mem_Ready = 1 on the same cycle the counter reaches TMO completes the access normally.
- Latency, in cycles, with zero memory wait:
  - NOP 2; BEQ and JMP 3; R-type, ADDI and ST 4; LD 5.
  - Each wait cycle adds 1.
- Instr_Count wraps modulo 2^CNTW.
- Mem_Ready outside FETCH and MEM is ignored.
- Mem_Rd and Mem_Wr are never asserted together.

Decomposition:
- Package mp_pkg holds:
  - the state enum: FETCH, DECODE, EXEC, MEM, WB, HALT;
  - opcode localparams;
  - ALU_Op, PC_Src and Err encodings.
- Sub-module mp_wait_timer: the wait counter, with inputs start, ready and clear and output timeout; parameter TMO.
- The FSM and output decode stay in mp_control_fsm.

Test Plan:
- Reset, then ADD with Mem_Ready tied to 1:
  - IR_En pulses in cycle 1, EXEC has ALU_Op = 0, Reg_Wr = 1 in cycle 4;
  - Instr_Count = 1; the next FETCH starts in cycle 5.
- LD with Mem_Ready low for 3 cycles in MEM:
  - Mem_Rd and Addr_Src = 1 are held for 4 cycles; WB has Wb_Src = 1 and Reg_Wr = 1;
  - total 8 cycles.
- BEQ with Zero = 1, then BEQ with Zero = 0:
  - with Zero = 1, PC_En = 1 and PC_Src = 1 in EXEC;
  - with Zero = 0, PC_En = 0;
  - both take 3 cycles and Instr_Count += 2.
- Opcode B → Err = 1 and Halted = 1 after DECODE; afterwards all outputs stay 0 even with Mem_Ready toggling.
- Mem_Ready held at 0 in FETCH:
  - with TMO = 15, Err = 2 and Halted = 1 once the counter reaches 15;
  - IR_En is never asserted.
- HLT, then Reset pulsed for 1 cycle:
  - Halted goes to 0, Instr_Count = 0, state = FETCH;
  - Mem_Rd = 1 on the cycle after Reset deasserts.

Source files
------------

// File: rtl/mp_pkg.sv
// rtl/mp_pkg.sv - shared types and encodings for the Microprocesador control unit
//   state_t         : control FSM states
//   OP_*            : instruction opcodes held in IR[15:12]
//   ALU_*, PC_SRC_*, ERR_* : output field encodings
//   is_legal()      : true for every opcode outside A..E
package mp_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_ADDI = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    localparam logic [1:0] PC_SRC_INC = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic logic is_legal(input logic [3:0] op);
        return !((op >= 4'hA) && (op <= 4'hE));
    endfunction

endpackage

// File: rtl/mp_wait_timer.sv
// rtl/mp_wait_timer.sv - memory wait counter with timeout flag
//   clk     : system clock
//   start   : entering a waiting state (FETCH or MEM); clears the count
//   ready   : memory completed the access; clears the count
//   clear   : synchronous clear (reset)
//   timeout : count has reached TMO
module mp_wait_timer #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic start,
    input  logic ready,
    input  logic clear,
    output logic timeout
);

    localparam int W = (TMO < 2) ? 1 : $clog2(TMO + 1);
    localparam logic [W-1:0] LIMIT = W'(TMO);

    logic [W-1:0] cnt;

    // Counts every cycle it is not cleared; it is only meaningful while the
    // FSM sits in FETCH or MEM, and saturates so it can never wrap past TMO.
    always_ff @(posedge clk) begin
        if (clear || start || ready) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + W'(1);
        end
    end

    assign timeout = (cnt == LIMIT);

endmodule

// File: rtl/mp_control_fsm.sv
// rtl/mp_control_fsm.sv - multicycle control unit for the Microprocesador datapath
//   Clk, Reset            : clock, synchronous active-high reset
//   Opcode, Zero          : IR[15:12] and ALU zero flag
//   Mem_Ready             : memory access completes this cycle
//   PC_En, PC_Src, IR_En  : PC / IR load controls
//   Mem_Rd, Mem_Wr, Addr_Src : memory request and address select
//   ALU_Op, ALU_SrcB      : ALU function and B operand select
//   Reg_Wr, Wb_Src        : register write enable and writeback select
//   Halted, Err           : stopped flag and sticky error code
//   Instr_Count           : retired instruction counter
module mp_control_fsm
    import mp_pkg::*;
#(
    parameter int OPW  = 4,
    parameter int TMO  = 15,
    parameter int CNTW = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [OPW-1:0]  Opcode,
    input  logic            Zero,
    input  logic            Mem_Ready,
    output logic            PC_En,
    output logic [1:0]      PC_Src,
    output logic            IR_En,
    output logic            Mem_Rd,
    output logic            Mem_Wr,
    output logic            Addr_Src,
    output logic [1:0]      ALU_Op,
    output logic            ALU_SrcB,
    output logic            Reg_Wr,
    output logic            Wb_Src,
    output logic            Halted,
    output logic [1:0]      Err,
    output logic [CNTW-1:0] Instr_Count
);

    state_t     state, state_n;
    logic [3:0] op;
    logic       retire;
    logic       set_err;
    logic [1:0] err_code;
    logic       timer_start;
    logic       timeout;

    assign op = Opcode[3:0];

    mp_wait_timer #(.TMO(TMO)) u_wait_timer (
        .clk     (Clk),
        .start   (timer_start),
        .ready   (Mem_Ready),
        .clear   (Reset),
        .timeout (timeout)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= FETCH;
            Err         <= ERR_NONE;
            Instr_Count <= '0;
        end else begin
            state <= state_n;
            if (set_err) begin
                Err <= err_code;
            end
            if (retire) begin
                Instr_Count <= Instr_Count + CNTW'(1);
            end
        end
    end

    always_comb begin
        state_n  = state;
        PC_En    = 1'b0;
        PC_Src   = PC_SRC_INC;
        IR_En    = 1'b0;
        Mem_Rd   = 1'b0;
        Mem_Wr   = 1'b0;
        Addr_Src = 1'b0;
        ALU_Op   = ALU_ADD;
        ALU_SrcB = 1'b0;
        Reg_Wr   = 1'b0;
        Wb_Src   = 1'b0;
        retire   = 1'b0;
        set_err  = 1'b0;
        err_code = ERR_NONE;

        unique case (state)
            FETCH: begin
                Mem_Rd = 1'b1;
                // Ready wins over timeout when both land on the same cycle.
                if (Mem_Ready) begin
                    IR_En   = 1'b1;
                    PC_En   = 1'b1;
                    state_n = DECODE;
                end else if (timeout) begin
                    set_err  = 1'b1;
                    err_code = ERR_TIMEOUT;
                    state_n  = HALT;
                end
            end

            DECODE: begin
                if (op == OP_NOP) begin
                    retire  = 1'b1;
                    state_n = FETCH;
                end else if (op == OP_HLT) begin
                    state_n = HALT;
                end else if (!is_legal(op)) begin
                    set_err  = 1'b1;
                    err_code = ERR_ILLEGAL;
                    state_n  = HALT;
                end else begin
                    state_n = EXEC;
                end
            end

            EXEC: begin
                case (op)
                    OP_SUB, OP_BEQ: ALU_Op = ALU_SUB;
                    OP_AND:         ALU_Op = ALU_AND;
                    OP_OR:          ALU_Op = ALU_OR;
                    default:        ALU_Op = ALU_ADD;
                endcase
                ALU_SrcB = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
                if (op == OP_BEQ) begin
                    PC_En   = Zero;
                    PC_Src  = PC_SRC_BR;
                    retire  = 1'b1;
                    state_n = FETCH;
                end else if (op == OP_JMP) begin
                    PC_En   = 1'b1;
                    PC_Src  = PC_SRC_JMP;
                    retire  = 1'b1;
                    state_n = FETCH;
                end else if ((op == OP_LD) || (op == OP_ST)) begin
                    state_n = MEM;
                end else begin
                    state_n = WB;
                end
            end

            MEM: begin
                Addr_Src = 1'b1;
                Mem_Rd   = (op == OP_LD);
                Mem_Wr   = (op == OP_ST);
                if (Mem_Ready) begin
                    if (op == OP_ST) begin
                        retire  = 1'b1;
                        state_n = FETCH;
                    end else begin
                        state_n = WB;
                    end
                end else if (timeout) begin
                    set_err  = 1'b1;
                    err_code = ERR_TIMEOUT;
                    state_n  = HALT;
                end
            end

            WB: begin
                Reg_Wr  = 1'b1;
                Wb_Src  = (op == OP_LD);
                retire  = 1'b1;
                state_n = FETCH;
            end

            HALT: begin
                state_n = HALT;
            end

            default: begin
                state_n = HALT;
            end
        endcase
    end

    // The wait counter restarts on every fresh entry into a waiting state.
    assign timer_start = ((state_n == FETCH) || (state_n == MEM)) && (state_n != state);
    assign Halted      = (state == HALT);

endmodule

// File: tb/tb_mp_control_fsm.sv
// tb/tb_mp_control_fsm.sv - directed scoreboard bench for mp_control_fsm
module tb_mp_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Opcode = 4'h0;
    logic        Zero = 1'b0;
    logic        Mem_Ready = 1'b0;
    logic        PC_En;
    logic [1:0]  PC_Src;
    logic        IR_En;
    logic        Mem_Rd;
    logic        Mem_Wr;
    logic        Addr_Src;
    logic [1:0]  ALU_Op;
    logic        ALU_SrcB;
    logic        Reg_Wr;
    logic        Wb_Src;
    logic        Halted;
    logic [1:0]  Err;
    logic [15:0] Instr_Count;

    int vectors = 0;
    int miscompares = 0;
    logic [30:0] exp_q[$];

    mp_control_fsm #(.OPW(4), .TMO(15), .CNTW(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Opcode      (Opcode),
        .Zero        (Zero),
        .Mem_Ready   (Mem_Ready),
        .PC_En       (PC_En),
        .PC_Src      (PC_Src),
        .IR_En       (IR_En),
        .Mem_Rd      (Mem_Rd),
        .Mem_Wr      (Mem_Wr),
        .Addr_Src    (Addr_Src),
        .ALU_Op      (ALU_Op),
        .ALU_SrcB    (ALU_SrcB),
        .Reg_Wr      (Reg_Wr),
        .Wb_Src      (Wb_Src),
        .Halted      (Halted),
        .Err         (Err),
        .Instr_Count (Instr_Count)
    );

    always #5 Clk = ~Clk;

    function automatic logic [14:0] o(input logic pe, input logic [1:0] ps, input logic ir,
                                      input logic rd, input logic wr, input logic as,
                                      input logic [1:0] alu, input logic sb, input logic rw,
                                      input logic wb, input logic h, input logic [1:0] er);
        return {pe, ps, ir, rd, wr, as, alu, sb, rw, wb, h, er};
    endfunction

    function automatic logic [14:0] exv(input logic [1:0] alu, input logic sb);
        return o(0, 2'd0, 0, 0, 0, 0, alu, sb, 0, 0, 0, 2'd0);
    endfunction

    function automatic logic [14:0] wbv(input logic wb);
        return o(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 1, wb, 0, 2'd0);
    endfunction

    function automatic logic [14:0] hv(input logic [1:0] er);
        return o(0, 2'd0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, er);
    endfunction

    logic [14:0] F1, F0, ZV, MRD, MWR;

    // Drive one cycle of inputs at the falling edge, record the expectation,
    // then compare the settled outputs before the next rising edge.
    task automatic step(input string tag, input logic rst, input logic [3:0] op,
                        input logic z, input logic rdy, input logic [14:0] ev,
                        input logic [15:0] ec);
        logic [30:0] got, want;
        @(negedge Clk);
        Reset     = rst;
        Opcode    = op;
        Zero      = z;
        Mem_Ready = rdy;
        exp_q.push_back({ev, ec});
        #1;
        got  = {PC_En, PC_Src, IR_En, Mem_Rd, Mem_Wr, Addr_Src, ALU_Op, ALU_SrcB,
                Reg_Wr, Wb_Src, Halted, Err, Instr_Count};
        want = exp_q.pop_front();
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        F1  = o(1, 2'd0, 1, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0);
        F0  = o(0, 2'd0, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0);
        ZV  = '0;
        MRD = o(0, 2'd0, 0, 1, 0, 1, 2'd0, 0, 0, 0, 0, 2'd0);
        MWR = o(0, 2'd0, 0, 0, 1, 1, 2'd0, 0, 0, 0, 0, 2'd0);

        step("rst_state", 1, 4'h0, 0, 0, F0, 16'd0);

        step("add_fetch",  0, 4'h1, 0, 1, F1, 16'd0);
        step("add_decode", 0, 4'h1, 0, 1, ZV, 16'd0);
        step("add_exec",   0, 4'h1, 0, 1, exv(2'd0, 0), 16'd0);
        step("add_wb",     0, 4'h1, 0, 1, wbv(0), 16'd0);

        step("ld_fetch",  0, 4'h6, 0, 1, F1, 16'd1);
        step("ld_decode", 0, 4'h6, 0, 1, ZV, 16'd1);
        step("ld_exec",   0, 4'h6, 0, 1, exv(2'd0, 1), 16'd1);
        for (int i = 0; i < 3; i++) step("ld_mem_wait", 0, 4'h6, 0, 0, MRD, 16'd1);
        step("ld_mem_done", 0, 4'h6, 0, 1, MRD, 16'd1);
        step("ld_wb",       0, 4'h6, 0, 1, wbv(1), 16'd1);

        step("beq1_fetch",  0, 4'h8, 1, 1, F1, 16'd2);
        step("beq1_decode", 0, 4'h8, 1, 1, ZV, 16'd2);
        step("beq1_exec",   0, 4'h8, 1, 1, o(1, 2'd1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0), 16'd2);
        step("beq0_fetch",  0, 4'h8, 0, 1, F1, 16'd3);
        step("beq0_decode", 0, 4'h8, 0, 1, ZV, 16'd3);
        step("beq0_exec",   0, 4'h8, 0, 1, o(0, 2'd1, 0, 0, 0, 0, 2'd1, 0, 0, 0, 0, 2'd0), 16'd3);

        step("st_fetch",  0, 4'h7, 0, 1, F1, 16'd4);
        step("st_decode", 0, 4'h7, 0, 1, ZV, 16'd4);
        step("st_exec",   0, 4'h7, 0, 1, exv(2'd0, 1), 16'd4);
        step("st_mem",    0, 4'h7, 0, 1, MWR, 16'd4);

        step("jmp_fetch",  0, 4'h9, 0, 1, F1, 16'd5);
        step("jmp_decode", 0, 4'h9, 0, 1, ZV, 16'd5);
        step("jmp_exec",   0, 4'h9, 0, 1, o(1, 2'd2, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 2'd0), 16'd5);

        step("nop_fetch",  0, 4'h0, 0, 1, F1, 16'd6);
        step("nop_decode", 0, 4'h0, 0, 1, ZV, 16'd6);

        step("sub_fetch",  0, 4'h2, 0, 1, F1, 16'd7);
        step("sub_decode", 0, 4'h2, 0, 1, ZV, 16'd7);
        step("sub_exec",   0, 4'h2, 0, 1, exv(2'd1, 0), 16'd7);
        step("sub_wb",     0, 4'h2, 0, 1, wbv(0), 16'd7);
        step("and_fetch",  0, 4'h3, 0, 1, F1, 16'd8);
        step("and_decode", 0, 4'h3, 0, 1, ZV, 16'd8);
        step("and_exec",   0, 4'h3, 0, 1, exv(2'd2, 0), 16'd8);
        step("and_wb",     0, 4'h3, 0, 1, wbv(0), 16'd8);
        step("or_fetch",   0, 4'h4, 0, 1, F1, 16'd9);
        step("or_decode",  0, 4'h4, 0, 1, ZV, 16'd9);
        step("or_exec",    0, 4'h4, 0, 1, exv(2'd3, 0), 16'd9);
        step("or_wb",      0, 4'h4, 0, 1, wbv(0), 16'd9);
        step("addi_fetch", 0, 4'h5, 0, 1, F1, 16'd10);
        step("addi_decode",0, 4'h5, 0, 1, ZV, 16'd10);
        step("addi_exec",  0, 4'h5, 0, 1, exv(2'd0, 1), 16'd10);
        step("addi_wb",    0, 4'h5, 0, 1, wbv(0), 16'd10);

        // Ready arrives exactly as the counter reaches TMO: normal completion.
        for (int i = 0; i < 15; i++) step("fetch_wait", 0, 4'h0, 0, 0, F0, 16'd11);
        step("fetch_ready_at_tmo", 0, 4'h0, 0, 1, F1, 16'd11);
        step("nop2_decode",        0, 4'h0, 0, 1, ZV, 16'd11);

        // Ready never arrives: bus timeout.
        for (int i = 0; i < 16; i++) step("fetch_wait_tmo", 0, 4'h0, 0, 0, F0, 16'd12);
        for (int i = 0; i < 4; i++) step("tmo_halt", 0, 4'h0, 0, 1'(i), hv(2'd2), 16'd12);

        step("rst_from_tmo", 1, 4'h0, 0, 0, hv(2'd2), 16'd12);
        step("post_rst_fetch", 0, 4'h0, 0, 0, F0, 16'd0);

        step("ill_fetch",  0, 4'hB, 0, 1, F1, 16'd0);
        step("ill_decode", 0, 4'hB, 0, 1, ZV, 16'd0);
        for (int i = 0; i < 4; i++) step("ill_halt", 0, 4'hB, 0, 1'(i), hv(2'd1), 16'd0);

        step("rst_from_ill", 1, 4'h0, 0, 0, hv(2'd1), 16'd0);
        step("hlt_fetch",  0, 4'hF, 0, 1, F1, 16'd0);
        step("hlt_decode", 0, 4'hF, 0, 1, ZV, 16'd0);
        step("hlt_halt0",  0, 4'hF, 0, 0, hv(2'd0), 16'd0);
        step("hlt_halt1",  0, 4'hF, 0, 1, hv(2'd0), 16'd0);
        step("rst_from_hlt", 1, 4'h0, 0, 0, hv(2'd0), 16'd0);
        step("post_hlt_rst_fetch", 0, 4'h0, 0, 0, F0, 16'd0);

        // Memory stage timeout on a load: no writeback follows.
        step("ldt_fetch",  0, 4'h6, 0, 1, F1, 16'd0);
        step("ldt_decode", 0, 4'h6, 0, 0, ZV, 16'd0);
        step("ldt_exec",   0, 4'h6, 0, 0, exv(2'd0, 1), 16'd0);
        for (int i = 0; i < 16; i++) step("ldt_mem_wait", 0, 4'h6, 0, 0, MRD, 16'd0);
        step("ldt_halt", 0, 4'h6, 0, 0, hv(2'd2), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
